alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial sequencer that drives a single 1-bit ALU slice, LSB first, to evaluate a full WIDTH-bit ALU operation over WIDTH cycles.
- Accepts operands and a 4-bit ALU control word through a start/busy/done handshake.
- Ripples carry through a registered carry flop and assembles the result in a shift register.
- Produces result, zero, carry-out and overflow flags.
- Serves as the area-minimal, multi-cycle counterpart to the combinational ripple ALU in the datapath.

## Interface

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- src1  input  WIDTH  operand A, latched on accepted start
- src2  input  WIDTH  operand B, latched on accepted start
- ALU_control  input  4  {A_invert, B_invert, operation[1:0]}, latched on accepted start
- result  output  WIDTH  final result, held until next done
- zero  output  1  result == 0
- cout  output  1  carry out of MSB (add/sub/slt); 0 otherwise
- overflow  output  1  signed overflow (add/sub); 0 otherwise
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when outputs update

## Operation

Supported control codes:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB
- 0111 SLT
- 1100 NOR
- 1101 NAND

Any other code runs the full WIDTH cycles and yields result=0, cout=0, overflow=0, zero=1.

Per-bit slice behaviour, at bit index i:
- a' = src1[i]^A_invert; b' = src2[i]^B_invert.
- op 00 → a'&b'; op 01 → a'|b'; op 10 → a'+b'+c; op 11 → 0 (bit 0 is patched for SLT).
- Carry c is initialised to B_invert at start, then updated every RUN cycle as maj(a',b',c).

FSM states:
- IDLE: start=1 latches operands and control, clears bit index and result shift register, sets c=B_invert, moves to RUN.
- RUN: processes bit index i each cycle and shifts the result bit in at the MSB end (shift right). After i = WIDTH-1 it moves to DONE.
- DONE: done=1 for this one cycle, then returns to IDLE.

Flags, registered on the RUN→DONE edge:
- cout = final carry.
- overflow = carry into MSB XOR carry out of MSB, for ADD/SUB only.
- For SLT: result = {WIDTH-1 zeros, set}, with cout as for SUB and overflow forced to 0.
- zero is computed on the final result.

Other rules:
- start while busy or in DONE: ignored, with no queuing.
- Operand inputs may change freely after acceptance.

## Timing

- Reset (asynchronous): state=IDLE; result=0, zero=0, cout=0, overflow=0, busy=0, done=0; internal shift/carry/index registers = 0.
- Reset mid-RUN aborts the operation. No done is issued.
- Start accepted at edge E0. busy=1 from E0 until edge EWIDTH.
- result, flags and done=1 are all valid after EWIDTH, for one cycle. done drops and the FSM reaches IDLE at EWIDTH+1.
- Latency from start to done is WIDTH+1 clocks.
- Back-to-back throughput is one op per WIDTH+2 cycles: start is first sampleable in the IDLE cycle after DONE.
- result and flags stay stable from done until the next done. They do not change during RUN.

## Configuration

- Macro: ALU_SERIAL_SLT_OVF_EN
- Defined: set = sum MSB XOR (carry-in to MSB XOR carry-out), giving a signed-correct less-than under subtraction overflow.
- Undefined: set = sum MSB only, matching the plain ripple ALU's set output. This is wrong when the subtraction overflows.

## Test plan

- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow=1, cout=0, zero=0; done exactly 33 clocks after the start edge.
- SUB 0x00000005 − 0x00000005 → result 0x00000000, zero=1, cout=1, overflow=0. NOR 0xF0F0F0F0, 0x0F0F0F00 → 0x0000000F.
- SLT 0xFFFFFFFF vs 0x00000001 → result 0x00000001. SLT 0x80000000 vs 0x00000001 → 0x00000001 with the macro defined, 0x00000000 without it.
- start held high through a whole op with different operands → only one op executes, and a second starts on the first IDLE cycle after done. Check the NAND 0xFFFFFFFF,0xFFFF0000 → 0x0000FFFF result is unaffected.
- Assert rst at cycle 10 of a RUN → all outputs 0 at once and no done pulse. A subsequent ADD 3+4 → 0x00000007.
- Undefined code 0011 with src1=src2=0xFFFFFFFF → result 0, zero=1, cout=0, overflow=0 after the full latency.

Source files
------------

// File: rtl/alu_serial_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_ctrl_if
// Description : Handshake and operand/result bundle for the bit-serial ALU
//               sequencer. The master issues start plus operands and control.
//               The slave returns the result, the flags and busy/done.
//   start       master -> slave  request, sampled only while the slave is idle
//   src1, src2  master -> slave  WIDTH-bit operands A and B
//   ALU_control master -> slave  {A_invert, B_invert, operation[1:0]}
//   result      slave -> master  WIDTH-bit result, held until the next done
//   zero, cout, overflow  slave -> master  result flags
//   busy, done  slave -> master  operation in progress / one-cycle completion
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [3:0]       ALU_control;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, src1, src2, ALU_control,
        input  result, zero, cout, overflow, busy, done
    );

    modport slave (
        input  start, src1, src2, ALU_control,
        output result, zero, cout, overflow, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_ctrl
// Description : Bit-serial sequencer for a single 1-bit ALU slice. It handles
//               bits LSB first and evaluates one WIDTH-bit ALU operation over
//               WIDTH RUN cycles. Carry ripples through a registered flop, and
//               the result is assembled in a right-shifting register.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : alu_serial_ctrl_if.slave
//          (start/src1/src2/ALU_control in; result/zero/cout/overflow/busy/done out)
//   Optional macro ALU_SERIAL_SLT_OVF_EN: when it is defined, the SLT set bit
//   is corrected for signed overflow of the subtraction.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_serial_ctrl_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state_q, r_state_d;
    logic [WIDTH-1:0] r_a_q, r_a_d;
    logic [WIDTH-1:0] r_b_q, r_b_d;
    logic [3:0]       r_ctrl_q, r_ctrl_d;
    logic [IW-1:0]    r_idx_q, r_idx_d;
    logic [WIDTH-1:0] r_shift_q, r_shift_d;
    logic             r_carry_q, r_carry_d;
    logic [WIDTH-1:0] r_result_q, r_result_d;
    logic             r_zero_q, r_zero_d;
    logic             r_cout_q, r_cout_d;
    logic             r_ovf_q, r_ovf_d;

    logic             w_a_bit, w_b_bit, w_sum, w_carry_nxt, w_slice;
    logic             w_ovf_raw, w_set, w_last;
    logic             w_op_valid, w_is_addsub, w_is_slt;
    logic [WIDTH-1:0] w_shift_nxt, w_final;

    // Operands shift right every RUN cycle, so the current bit is always at [0].
    assign w_a_bit     = r_a_q[0] ^ r_ctrl_q[3];
    assign w_b_bit     = r_b_q[0] ^ r_ctrl_q[2];
    assign w_sum       = w_a_bit ^ w_b_bit ^ r_carry_q;
    assign w_carry_nxt = (w_a_bit & w_b_bit) | (w_a_bit & r_carry_q) | (w_b_bit & r_carry_q);
    assign w_last      = (r_idx_q == IW'(WIDTH - 1));
    assign w_shift_nxt = {w_slice, r_shift_q[WIDTH-1:1]};

    // At the MSB step, r_carry_q is the carry into the MSB and w_carry_nxt is the carry out.
    assign w_ovf_raw   = r_carry_q ^ w_carry_nxt;

`ifdef ALU_SERIAL_SLT_OVF_EN
    assign w_set = w_sum ^ w_ovf_raw;
`else
    assign w_set = w_sum;
`endif

    always_comb begin
        w_slice = 1'b0;
        case (r_ctrl_q[1:0])
            2'b00:   w_slice = w_a_bit & w_b_bit;
            2'b01:   w_slice = w_a_bit | w_b_bit;
            2'b10:   w_slice = w_sum;
            default: w_slice = 1'b0;
        endcase
    end

    always_comb begin
        w_op_valid  = 1'b0;
        w_is_addsub = 1'b0;
        w_is_slt    = 1'b0;
        case (r_ctrl_q)
            4'b0000, 4'b0001, 4'b1100, 4'b1101: w_op_valid = 1'b1;
            4'b0010, 4'b0110: begin
                w_op_valid  = 1'b1;
                w_is_addsub = 1'b1;
            end
            4'b0111: begin
                w_op_valid = 1'b1;
                w_is_slt   = 1'b1;
            end
            default: w_op_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_final = '0;
        if (!w_op_valid) begin
            w_final = '0;
        end else if (w_is_slt) begin
            w_final = {{(WIDTH-1){1'b0}}, w_set};
        end else begin
            w_final = w_shift_nxt;
        end
    end

    always_comb begin
        r_state_d  = r_state_q;
        r_a_d      = r_a_q;
        r_b_d      = r_b_q;
        r_ctrl_d   = r_ctrl_q;
        r_idx_d    = r_idx_q;
        r_shift_d  = r_shift_q;
        r_carry_d  = r_carry_q;
        r_result_d = r_result_q;
        r_zero_d   = r_zero_q;
        r_cout_d   = r_cout_q;
        r_ovf_d    = r_ovf_q;
        case (r_state_q)
            S_IDLE: begin
                if (bus.start) begin
                    r_a_d     = bus.src1;
                    r_b_d     = bus.src2;
                    r_ctrl_d  = bus.ALU_control;
                    r_idx_d   = '0;
                    r_shift_d = '0;
                    // The B_invert carry-in supplies the +1 of two's-complement subtraction.
                    r_carry_d = bus.ALU_control[2];
                    r_state_d = S_RUN;
                end
            end
            S_RUN: begin
                r_a_d     = r_a_q >> 1;
                r_b_d     = r_b_q >> 1;
                r_shift_d = w_shift_nxt;
                r_carry_d = w_carry_nxt;
                r_idx_d   = r_idx_q + IW'(1);
                if (w_last) begin
                    r_idx_d    = '0;
                    r_state_d  = S_DONE;
                    r_result_d = w_final;
                    r_zero_d   = (w_final == '0);
                    r_cout_d   = (w_is_addsub || w_is_slt) ? w_carry_nxt : 1'b0;
                    r_ovf_d    = w_is_addsub ? w_ovf_raw : 1'b0;
                end
            end
            S_DONE:  r_state_d = S_IDLE;
            default: r_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_ctrl_q   <= '0;
            r_idx_q    <= '0;
            r_shift_q  <= '0;
            r_carry_q  <= 1'b0;
            r_result_q <= '0;
            r_zero_q   <= 1'b0;
            r_cout_q   <= 1'b0;
            r_ovf_q    <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            r_a_q      <= r_a_d;
            r_b_q      <= r_b_d;
            r_ctrl_q   <= r_ctrl_d;
            r_idx_q    <= r_idx_d;
            r_shift_q  <= r_shift_d;
            r_carry_q  <= r_carry_d;
            r_result_q <= r_result_d;
            r_zero_q   <= r_zero_d;
            r_cout_q   <= r_cout_d;
            r_ovf_q    <= r_ovf_d;
        end
    end

    assign bus.result   = r_result_q;
    assign bus.zero     = r_zero_q;
    assign bus.cout     = r_cout_q;
    assign bus.overflow = r_ovf_q;
    assign bus.busy     = (r_state_q == S_RUN);
    assign bus.done     = (r_state_q == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_ctrl
// Description : Scoreboard bench for alu_serial_ctrl with WIDTH=32. The
//               stimulus pushes hand-computed expectations, and a monitor pops
//               and compares them on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_ctrl;
    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        o;
        string       nm;
    } exp_t;

    logic clk;
    logic rst;
    int   asserts;
    int   fails;
    exp_t q[$];

    alu_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                asserts++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.nm, "_result"},   bus.result,          e.r);
                check({e.nm, "_zero"},     {31'd0, bus.zero},     {31'd0, e.z});
                check({e.nm, "_cout"},     {31'd0, bus.cout},     {31'd0, e.c});
                check({e.nm, "_overflow"}, {31'd0, bus.overflow}, {31'd0, e.o});
            end
        end
    end

    // Waits for done, starting after the accept edge, which counts as clock 1.
    task automatic wait_done(input string nm, input logic [31:0] r0);
        int n;
        int chg;
        bit got;
        n = 1;
        chg = 0;
        got = 0;
        while (!got && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.done === 1'b1) got = 1;
            else if (bus.result !== r0) chg++;
        end
        check({nm, "_latency"}, n, 33);
        check({nm, "_stable"}, chg, 0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                          input logic [31:0] er, input logic ez, input logic ec, input logic eo,
                          input string nm);
        logic [31:0] r0;
        @(negedge clk);
        bus.src1 = a;
        bus.src2 = b;
        bus.ALU_control = c;
        bus.start = 1'b1;
        q.push_back('{er, ez, ec, eo, nm});
        r0 = bus.result;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.src1 = ~a;
        bus.src2 = ~b;
        bus.ALU_control = ~c;
        check({nm, "_busy"}, {31'd0, bus.busy}, 32'd1);
        wait_done(nm, r0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] slt2;
        logic [31:0] r0;
        int ndone;
        int w;
        asserts = 0;
        fails = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.src1 = '0;
        bus.src2 = '0;
        bus.ALU_control = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result",   bus.result,              32'd0);
        check("rst_flags",    {28'd0, bus.zero, bus.cout, bus.overflow, bus.busy}, 32'd0);
        check("rst_done",     {31'd0, bus.done},         32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1, "add_ovf");
        run_op(32'h00000005, 32'h00000005, 4'b0110, 32'h00000000, 1'b1, 1'b1, 1'b0, "sub_eq");
        run_op(32'hF0F0F0F0, 32'h0F0F0F00, 4'b1100, 32'h0000000F, 1'b0, 1'b0, 1'b0, "nor");
        run_op(32'h12345678, 32'h0F0F0F0F, 4'b0000, 32'h02040608, 1'b0, 1'b0, 1'b0, "and");
        run_op(32'h12345678, 32'h0F0F0F0F, 4'b0001, 32'h1F3F5F7F, 1'b0, 1'b0, 1'b0, "or");
        run_op(32'h00000000, 32'h00000001, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "sub_neg");
        run_op(32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 1'b1, 1'b1, 1'b0, "add_wrap");
        run_op(32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 1'b0, 1'b1, 1'b0, "slt_neg");
`ifdef ALU_SERIAL_SLT_OVF_EN
        slt2 = 32'h00000001;
`else
        slt2 = 32'h00000000;
`endif
        run_op(32'h80000000, 32'h00000001, 4'b0111, slt2, (slt2 == 32'd0), 1'b1, 1'b0, "slt_ovf");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0011, 32'h00000000, 1'b1, 1'b0, 1'b0, "undef");

        // Start is held high through a whole op. The second op starts only in IDLE after DONE.
        @(negedge clk);
        bus.src1 = 32'hFFFFFFFF;
        bus.src2 = 32'hFFFF0000;
        bus.ALU_control = 4'b1101;
        bus.start = 1'b1;
        q.push_back('{32'h0000FFFF, 1'b0, 1'b0, 1'b0, "nand_held"});
        q.push_back('{32'h00000002, 1'b0, 1'b0, 1'b0, "add_second"});
        r0 = bus.result;
        @(posedge clk);
        #1;
        bus.src1 = 32'h00000001;
        bus.src2 = 32'h00000001;
        bus.ALU_control = 4'b0010;
        wait_done("nand_held", r0);
        @(posedge clk);
        #1;
        check("held_idle_after_done", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check("held_second_accept", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        wait_done("add_second", 32'h0000FFFF);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN aborts the operation with no done pulse.
        @(negedge clk);
        bus.src1 = 32'h00000010;
        bus.src2 = 32'h00000020;
        bus.ALU_control = 4'b0010;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_result", bus.result, 32'd0);
        check("abort_flags", {28'd0, bus.zero, bus.cout, bus.overflow, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("abort_no_done", ndone, 0);

        run_op(32'h00000003, 32'h00000004, 4'b0010, 32'h00000007, 1'b0, 1'b0, 1'b0, "add_after_rst");

        w = 0;
        while (q.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
`default_nettype wire
